// File: rtl/watchdog_pkg.sv
// Shared definitions for the watchdog serial loader and its receiver:
// default geometry and the transfer state encoding.
package watchdog_pkg;
    localparam int WD_WIDTH = 32;
    localparam int WD_PHASE = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOW   = 3'd2,
        DRIVE = 3'd3,
        HIGH  = 3'd4,
        HOLD  = 3'd5,
        GAP   = 3'd6
    } wd_state_e;
endpackage

// File: rtl/phase_timer.sv
// PHASE-cycle down-counter: load starts a phase, expire marks its last cycle.
module phase_timer
    import watchdog_pkg::*;
#(
    parameter int PHASE = WD_PHASE
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);
    localparam int CW = (PHASE > 1) ? $clog2(PHASE) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = CW'(PHASE - 1);
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == '0);
endmodule

// File: rtl/watchdog_loader.sv
// Serialises a timeout word MSB first to the watchdog over sel/sclk/sdo,
// each protocol phase lasting PHASE clock cycles.
module watchdog_loader
    import watchdog_pkg::*;
#(
    parameter int PHASE = WD_PHASE,
    parameter int WIDTH = WD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             sclk,
    output logic             sel,
    output logic             sdo,
    output logic             done
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    wd_state_e        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             sel_q, sel_d;
    logic             sclk_q, sclk_d;
    logic             sdo_q, sdo_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             accept;
    logic             load;
    logic             expire;

    phase_timer #(.PHASE(PHASE)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        accept  = valid && ready_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    shift_d = data;
                    idx_d   = IW'(WIDTH - 1);
                end
            end
            SETUP: if (expire) state_d = LOW;
            LOW:   if (expire) state_d = DRIVE;
            DRIVE: if (expire) state_d = HIGH;
            HIGH: begin
                if (expire) begin
                    shift_d = shift_q << 1;
                    if (idx_q != '0) begin
                        idx_d   = idx_q - 1'b1;
                        state_d = LOW;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD:    if (expire) state_d = GAP;
            GAP:     if (expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Every state transition into a timed state restarts the phase.
        load = (state_d != state_q) && (state_d != IDLE);

        // Outputs are decoded from the next state so the registers line up
        // with the state they describe.
        sel_d   = (state_d == SETUP) || (state_d == LOW) || (state_d == DRIVE) ||
                  (state_d == HIGH)  || (state_d == HOLD);
        sclk_d  = !((state_d == LOW) || (state_d == DRIVE));
        sdo_d   = (state_d == DRIVE) ? shift_q[WIDTH-1] : sdo_q;
        done_d  = (state_d == GAP) && (state_q != GAP);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            sel_q   <= 1'b0;
            sclk_q  <= 1'b1;
            sdo_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign sclk  = sclk_q;
    assign sel   = sel_q;
    assign sdo   = sdo_q;
    assign done  = done_q;
endmodule

// File: tb/tb_watchdog_loader.sv
// Directed bench: a PHASE=2 and a PHASE=1 loader, each looped back into a
// small behavioural watchdog receiver that captures on sclk rising edges.
module tb_watchdog_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_data, b_data;
    logic        a_valid, b_valid;
    logic        a_ready, a_sclk, a_sel, a_sdo, a_done;
    logic        b_ready, b_sclk, b_sel, b_sdo, b_done;

    int n_cmp = 0;
    int n_err = 0;

    watchdog_loader #(.PHASE(2), .WIDTH(32)) dut_a (
        .clk(clk), .rst(rst), .data(a_data), .valid(a_valid), .ready(a_ready),
        .sclk(a_sclk), .sel(a_sel), .sdo(a_sdo), .done(a_done)
    );

    watchdog_loader #(.PHASE(1), .WIDTH(32)) dut_b (
        .clk(clk), .rst(rst), .data(b_data), .valid(b_valid), .ready(b_ready),
        .sclk(b_sclk), .sel(b_sel), .sdo(b_sdo), .done(b_done)
    );

    always #5 clk = ~clk;

    // Receiver models and activity counters, sampled on the falling edge.
    logic [31:0] a_sh = '0, b_sh = '0;
    logic [31:0] a_words [16];
    logic [31:0] b_words [16];
    int a_nw = 0, b_nw = 0, a_fbits = 0, b_fbits = 0, a_bits = 0, b_bits = 0;
    int a_selcyc = 0, b_selcyc = 0, a_dones = 0, b_dones = 0, a_viol = 0, b_viol = 0;
    logic a_sel_p = 1'b0, a_sclk_p = 1'b1, a_sdo_p = 1'b0;
    logic b_sel_p = 1'b0, b_sclk_p = 1'b1, b_sdo_p = 1'b0;

    always @(negedge clk) begin
        if (a_sel && !a_sel_p) begin a_sh = '0; a_fbits = 0; end
        if (a_sel && a_sclk && !a_sclk_p) begin
            a_sh = {a_sh[30:0], a_sdo}; a_fbits++; a_bits++;
        end
        if (a_sel) a_selcyc++;
        if (!a_sel && a_sel_p && a_fbits == 32 && a_nw < 16) begin a_words[a_nw] = a_sh; a_nw++; end
        if (a_done) a_dones++;
        if (a_sel && a_sel_p && a_sclk && a_sclk_p && a_sdo !== a_sdo_p) a_viol++;
        a_sel_p = a_sel; a_sclk_p = a_sclk; a_sdo_p = a_sdo;
    end

    always @(negedge clk) begin
        if (b_sel && !b_sel_p) begin b_sh = '0; b_fbits = 0; end
        if (b_sel && b_sclk && !b_sclk_p) begin
            b_sh = {b_sh[30:0], b_sdo}; b_fbits++; b_bits++;
        end
        if (b_sel) b_selcyc++;
        if (!b_sel && b_sel_p && b_fbits == 32 && b_nw < 16) begin b_words[b_nw] = b_sh; b_nw++; end
        if (b_done) b_dones++;
        if (b_sel && b_sel_p && b_sclk && b_sclk_p && b_sdo !== b_sdo_p) b_viol++;
        b_sel_p = b_sel; b_sclk_p = b_sclk; b_sdo_p = b_sdo;
    end

    // Accept log: clock-cycle number of every valid&&ready edge.
    int cyc = 0, a_nacc = 0, b_nacc = 0;
    int a_acc [16];
    always @(posedge clk) begin
        cyc++;
        if (!rst && a_valid && a_ready) begin
            if (a_nacc < 16) a_acc[a_nacc] = cyc;
            a_nacc++;
        end
        if (!rst && b_valid && b_ready) b_nacc++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input bit b, input int budget);
        int n = 0;
        while (!(b ? b_ready : a_ready) && n < budget) begin step(); n++; end
        chk(b ? "ready_wait_b" : "ready_wait_a", 32'(b ? b_ready : a_ready), 32'd1);
    endtask

    task automatic wait_done(input bit b, input int target, input int budget);
        int n = 0;
        while ((b ? b_dones : a_dones) < target && n < budget) begin step(); n++; end
        chk(b ? "done_wait_b" : "done_wait_a", 32'((b ? b_dones : a_dones) >= target), 32'd1);
    endtask

    task automatic send(input bit b, input logic [31:0] d);
        wait_ready(b, 400);
        if (b) begin b_data = d; b_valid = 1'b1; end
        else   begin a_data = d; a_valid = 1'b1; end
        step();
        if (b) b_valid = 1'b0; else a_valid = 1'b0;
    endtask

    int s_bits, s_sel, s_done, s_nw, s_nacc, n;

    initial begin
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
        repeat (3) step();
        chk("rst_sel",   32'(a_sel),   32'd0);
        chk("rst_sclk",  32'(a_sclk),  32'd1);
        chk("rst_sdo",   32'(a_sdo),   32'd0);
        chk("rst_done",  32'(a_done),  32'd0);
        chk("rst_ready", 32'(a_ready), 32'd0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", 32'(a_ready), 32'd1);

        // Single transfer of 100
        s_bits = a_bits; s_sel = a_selcyc; s_done = a_dones; s_nw = a_nw;
        send(1'b0, 32'd100);
        wait_done(1'b0, s_done + 1, 400);
        wait_ready(1'b0, 20);
        repeat (5) step();
        chk("t1_sclk_rises", 32'(a_bits - s_bits),   32'd32);
        chk("t1_sel_cycles", 32'(a_selcyc - s_sel),  32'd196);
        chk("t1_done_count", 32'(a_dones - s_done),  32'd1);
        chk("t1_word",       a_words[s_nw],           32'h0000_0064);

        // Loopback of two timeout values
        s_nw = a_nw; s_done = a_dones;
        send(1'b0, 32'd1234);
        wait_done(1'b0, s_done + 1, 400);
        send(1'b0, 32'd1000);
        wait_done(1'b0, s_done + 2, 400);
        wait_ready(1'b0, 20);
        chk("t2_word0", a_words[s_nw],     32'd1234);
        chk("t2_word1", a_words[s_nw + 1], 32'd1000);

        // valid held high, data changed mid-transfer
        s_nacc = a_nacc; s_nw = a_nw; s_done = a_dones;
        a_data = 32'h1234_5678; a_valid = 1'b1;
        n = 0;
        while (a_nacc <= s_nacc && n < 10) begin step(); n++; end
        repeat (50) step();
        a_data = 32'h0F0F_0F0F;
        n = 0;
        while (a_nacc <= s_nacc + 1 && n < 400) begin step(); n++; end
        a_valid = 1'b0;
        chk("t3_spacing", 32'(a_acc[s_nacc + 1] - a_acc[s_nacc]), 32'd199);
        wait_done(1'b0, s_done + 2, 400);
        wait_ready(1'b0, 20);
        chk("t3_accepts", 32'(a_nacc - s_nacc), 32'd2);
        chk("t3_word0", a_words[s_nw],     32'h1234_5678);
        chk("t3_word1", a_words[s_nw + 1], 32'h0F0F_0F0F);

        // Reset at bit 10 of an all-ones word
        s_nw = a_nw; s_done = a_dones;
        send(1'b0, 32'hFFFF_FFFF);
        n = 0;
        while (!(a_sel && a_fbits == 10) && n < 200) begin step(); n++; end
        chk("t4_reached_bit10", 32'(a_fbits), 32'd10);
        rst = 1'b1;
        step();
        chk("t4_sel_dropped", 32'(a_sel),  32'd0);
        chk("t4_no_done",     32'(a_done), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("t4_ready_after", 32'(a_ready), 32'd1);
        repeat (20) step();
        chk("t4_done_count", 32'(a_dones - s_done), 32'd0);
        chk("t4_no_word",    32'(a_nw - s_nw),      32'd0);

        // PHASE=1 instance
        s_bits = b_bits; s_sel = b_selcyc; s_done = b_dones; s_nw = b_nw;
        send(1'b1, 32'hA5A5_A5A5);
        wait_done(1'b1, s_done + 1, 200);
        wait_ready(1'b1, 20);
        chk("t5_sclk_rises", 32'(b_bits - s_bits),  32'd32);
        chk("t5_sel_cycles", 32'(b_selcyc - s_sel), 32'd98);
        chk("t5_done_count", 32'(b_dones - s_done), 32'd1);
        chk("t5_word",       b_words[s_nw],          32'hA5A5_A5A5);

        // valid while busy is ignored and not queued
        s_nacc = a_nacc; s_nw = a_nw; s_done = a_dones;
        send(1'b0, 32'h00C0_FFEE);
        repeat (5) step();
        chk("t6_busy_ready", 32'(a_ready), 32'd0);
        a_data = 32'h0000_DEAD; a_valid = 1'b1;
        repeat (10) step();
        a_valid = 1'b0;
        wait_done(1'b0, s_done + 1, 400);
        wait_ready(1'b0, 20);
        repeat (10) step();
        chk("t6_not_queued", 32'(a_sel),            32'd0);
        chk("t6_accepts",    32'(a_nacc - s_nacc),  32'd1);
        chk("t6_word",       a_words[s_nw],         32'h00C0_FFEE);
        chk("sdo_stable_a",  32'(a_viol),           32'd0);
        chk("sdo_stable_b",  32'(b_viol),           32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
